// File: rtl/cpu_do_demux.sv
// Z80 data-out distribution: syncs the write strobe, edge-detects it and
// routes the captured byte to RAM, S100, LED, IOBYTE or USB TX.
module cpu_do_demux #(
  parameter int         SYNC_STAGES   = 2,
  parameter int         STROBE_CYCLES = 4,
  parameter logic [7:0] LED_RESET     = 8'h00,
  parameter logic [7:0] IOBYTE_RESET  = 8'hFF
) (
  input  logic       pll0_250MHz,
  input  logic       reset,
  input  logic [7:0] cpuDataOut,
  input  logic       z80Write,
  input  logic       ram_cs,
  input  logic       outPortcon_cs,
  input  logic       outLED_cs,
  input  logic       iobyteOut_cs,
  input  logic       usbTxD_cs,
  input  logic       usbTxReady,
  output logic [7:0] ramWrData,
  output logic       ramWe,
  output logic [7:0] s100DataOut,
  output logic       s100Wr,
  output logic [7:0] ledData,
  output logic [7:0] iobyteReg,
  output logic [7:0] usbTxData,
  output logic       usbTxValid,
  output logic       wrBusy,
  output logic       wrOverrun
);

  typedef enum logic {
    IDLE   = 1'b0,
    STROBE = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

  state_t stateQ;
  state_t stateD;

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   prevQ;
  logic                   evtQ;
  logic [3:0]             cntQ;
  logic                   tgtS100Q;

  logic selRam;
  logic selS100;
  logic selLed;
  logic selIob;
  logic selUsb;
  logic startStrobe;
  logic strobeDrop;
  logic usbXfer;
  logic usbLoad;
  logic usbDrop;

  // Fixed priority: ram > outPortcon > outLED > iobyteOut > usbTxD
  always_comb begin
    selRam  = 1'b0;
    selS100 = 1'b0;
    selLed  = 1'b0;
    selIob  = 1'b0;
    selUsb  = 1'b0;
    if (ram_cs)             selRam  = 1'b1;
    else if (outPortcon_cs) selS100 = 1'b1;
    else if (outLED_cs)     selLed  = 1'b1;
    else if (iobyteOut_cs)  selIob  = 1'b1;
    else if (usbTxD_cs)     selUsb  = 1'b1;
  end

  assign startStrobe = evtQ & (selRam | selS100)
                     & (stateQ == IDLE);
  assign strobeDrop  = evtQ & (selRam | selS100)
                     & (stateQ == STROBE);

  // A consumed holding byte frees the slot in the same clock
  assign usbXfer = usbTxValid & usbTxReady;
  assign usbLoad = evtQ & selUsb & (~usbTxValid | usbXfer);
  assign usbDrop = evtQ & selUsb & usbTxValid & ~usbTxReady;

  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      syncQ <= '0;
      prevQ <= 1'b0;
      evtQ  <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], z80Write};
      prevQ <= syncQ[SYNC_STAGES-1];
      evtQ  <= syncQ[SYNC_STAGES-1] & ~prevQ;
    end
  end

  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      stateQ   <= IDLE;
      cntQ     <= 4'd0;
      tgtS100Q <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (startStrobe) begin
        cntQ     <= CNT_LOAD;
        tgtS100Q <= selS100;
      end else if (stateQ == STROBE && cntQ != 4'd0) begin
        cntQ <= cntQ - 4'd1;
      end
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:   if (startStrobe) stateD = STROBE;
      STROBE: if (cntQ == 4'd0) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    ramWe  = 1'b0;
    s100Wr = 1'b0;
    wrBusy = 1'b0;
    if (stateQ == STROBE) begin
      wrBusy = 1'b1;
      ramWe  = ~tgtS100Q;
      s100Wr = tgtS100Q;
    end
  end

  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      ramWrData   <= 8'h00;
      s100DataOut <= 8'h00;
      ledData     <= LED_RESET;
      iobyteReg   <= IOBYTE_RESET;
    end else begin
      if (startStrobe && selRam)  ramWrData   <= cpuDataOut;
      if (startStrobe && selS100) s100DataOut <= cpuDataOut;
      if (evtQ && selLed)         ledData     <= cpuDataOut;
      if (evtQ && selIob)         iobyteReg   <= cpuDataOut;
    end
  end

  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      usbTxData  <= 8'h00;
      usbTxValid <= 1'b0;
    end else if (usbLoad) begin
      usbTxData  <= cpuDataOut;
      usbTxValid <= 1'b1;
    end else if (usbXfer) begin
      usbTxValid <= 1'b0;
    end
  end

  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      wrOverrun <= 1'b0;
    end else if (strobeDrop || usbDrop) begin
      wrOverrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_do_demux.sv
// Directed bench for cpu_do_demux: default instance plus a
// STROBE_CYCLES=15 instance for the long-pulse overrun case.
module tb_cpu_do_demux;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cpuDataOut = 8'h00;
  logic       z80Write = 1'b0;
  logic       ram_cs = 1'b0;
  logic       outPortcon_cs = 1'b0;
  logic       outLED_cs = 1'b0;
  logic       iobyteOut_cs = 1'b0;
  logic       usbTxD_cs = 1'b0;
  logic       usbTxReady = 1'b0;

  logic [7:0] ramWrData, s100DataOut, ledData, iobyteReg, usbTxData;
  logic       ramWe, s100Wr, usbTxValid, wrBusy, wrOverrun;

  logic [7:0] ramWrData15, s100DataOut15, ledData15, iobyteReg15;
  logic [7:0] usbTxData15;
  logic       ramWe15, s100Wr15, usbTxValid15, wrBusy15, wrOverrun15;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cpu_do_demux dut (
    .pll0_250MHz  (clk),
    .reset        (reset),
    .cpuDataOut   (cpuDataOut),
    .z80Write     (z80Write),
    .ram_cs       (ram_cs),
    .outPortcon_cs(outPortcon_cs),
    .outLED_cs    (outLED_cs),
    .iobyteOut_cs (iobyteOut_cs),
    .usbTxD_cs    (usbTxD_cs),
    .usbTxReady   (usbTxReady),
    .ramWrData    (ramWrData),
    .ramWe        (ramWe),
    .s100DataOut  (s100DataOut),
    .s100Wr       (s100Wr),
    .ledData      (ledData),
    .iobyteReg    (iobyteReg),
    .usbTxData    (usbTxData),
    .usbTxValid   (usbTxValid),
    .wrBusy       (wrBusy),
    .wrOverrun    (wrOverrun)
  );

  cpu_do_demux #(.STROBE_CYCLES(15)) dut15 (
    .pll0_250MHz  (clk),
    .reset        (reset),
    .cpuDataOut   (cpuDataOut),
    .z80Write     (z80Write),
    .ram_cs       (ram_cs),
    .outPortcon_cs(outPortcon_cs),
    .outLED_cs    (outLED_cs),
    .iobyteOut_cs (iobyteOut_cs),
    .usbTxD_cs    (usbTxD_cs),
    .usbTxReady   (usbTxReady),
    .ramWrData    (ramWrData15),
    .ramWe        (ramWe15),
    .s100DataOut  (s100DataOut15),
    .s100Wr       (s100Wr15),
    .ledData      (ledData15),
    .iobyteReg    (iobyteReg15),
    .usbTxData    (usbTxData15),
    .usbTxValid   (usbTxValid15),
    .wrBusy       (wrBusy15),
    .wrOverrun    (wrOverrun15)
  );

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // sel = {ram, outPortcon, outLED, iobyteOut, usbTxD}
  task automatic doWrite(input logic [7:0] d, input logic [4:0] sel,
                         output logic [15:0] weMask,
                         output logic [15:0] s1Mask,
                         output logic [15:0] bzMask);
    weMask = '0;
    s1Mask = '0;
    bzMask = '0;
    @(negedge clk);
    cpuDataOut = d;
    {ram_cs, outPortcon_cs, outLED_cs, iobyteOut_cs, usbTxD_cs} = sel;
    z80Write = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      weMask[i] = ramWe;
      s1Mask[i] = s100Wr;
      bzMask[i] = wrBusy;
      if (i == 5) z80Write = 1'b0;
    end
    {ram_cs, outPortcon_cs, outLED_cs, iobyteOut_cs, usbTxD_cs} = '0;
  endtask

  logic [15:0] we, s1, bz;
  int cnt15;

  initial begin
    doReset();
    check("rst_led", 16'(ledData), 16'h0000);
    check("rst_iob", 16'(iobyteReg), 16'h00FF);
    check("rst_ram", 16'(ramWrData), 16'h0000);
    check("rst_strb", 16'({ramWe, s100Wr}), 16'h0000);
    check("rst_flags", 16'({usbTxValid, wrBusy, wrOverrun}), 16'h0000);

    doWrite(8'hA5, 5'b10000, we, s1, bz);
    check("ram_data", 16'(ramWrData), 16'h00A5);
    check("ram_we_win", we, 16'h00F0);
    check("ram_busy_win", bz, 16'h00F0);
    check("ram_no_s100", s1, 16'h0000);

    doWrite(8'h3C, 5'b00100, we, s1, bz);
    check("led_data", 16'(ledData), 16'h003C);
    check("led_no_busy", bz, 16'h0000);

    doWrite(8'h81, 5'b01010, we, s1, bz);
    check("s100_data", 16'(s100DataOut), 16'h0081);
    check("s100_wr_win", s1, 16'h00F0);
    check("s100_no_ram", we, 16'h0000);
    check("iob_keep", 16'(iobyteReg), 16'h00FF);
    check("ram_keep", 16'(ramWrData), 16'h00A5);
    check("no_ovr", 16'(wrOverrun), 16'h0000);

    doWrite(8'h6E, 5'b00010, we, s1, bz);
    check("iob_data", 16'(iobyteReg), 16'h006E);

    usbTxReady = 1'b0;
    doWrite(8'h41, 5'b00001, we, s1, bz);
    check("usb_v1", 16'(usbTxValid), 16'h0001);
    check("usb_ovr0", 16'(wrOverrun), 16'h0000);
    doWrite(8'h42, 5'b00001, we, s1, bz);
    check("usb_data", 16'(usbTxData), 16'h0041);
    check("usb_valid", 16'(usbTxValid), 16'h0001);
    check("usb_ovr", 16'(wrOverrun), 16'h0001);
    usbTxReady = 1'b1;
    @(negedge clk);
    check("usb_xfer", 16'(usbTxValid), 16'h0000);
    usbTxReady = 1'b0;

    // Long pulse on dut15 with a second ram edge inside it
    doReset();
    @(negedge clk);
    cpuDataOut = 8'h11;
    ram_cs = 1'b1;
    z80Write = 1'b1;
    cnt15 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ramWe15) cnt15++;
      if (i == 4) z80Write = 1'b0;
      if (i == 7) begin
        cpuDataOut = 8'h22;
        z80Write = 1'b1;
      end
      if (i == 12) z80Write = 1'b0;
    end
    ram_cs = 1'b0;
    check("long_cnt", 16'(cnt15), 16'd15);
    check("long_ovr", 16'(wrOverrun15), 16'h0001);
    check("long_data", 16'(ramWrData15), 16'h0011);
    check("long_idle", 16'(wrBusy15), 16'h0000);

    // Reset in the middle of a pulse
    doReset();
    @(negedge clk);
    cpuDataOut = 8'h5A;
    ram_cs = 1'b1;
    z80Write = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_we_on", 16'(ramWe), 16'h0001);
    reset = 1'b1;
    z80Write = 1'b0;
    ram_cs = 1'b0;
    #1;
    check("mid_rst", 16'({ramWe, wrBusy}), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    doWrite(8'h77, 5'b10000, we, s1, bz);
    check("post_we", we, 16'h00F0);
    check("post_data", 16'(ramWrData), 16'h0077);
    check("post_ovr", 16'(wrOverrun), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
